// File: rtl/teclado_matriz.sv
// Matrix-keypad scanner: drives one column low at a time, debounces whole scan frames,
// rejects multi-key frames and hands each accepted press over a 1-deep valid/ready event.
module teclado_matriz #(
  parameter int N_FILAS         = 4,
  parameter int N_COLS          = 4,
  parameter int SCAN_DIV        = 13_500,
  parameter int DEBOUNCE_FRAMES = 4,
  localparam int KEYS = N_FILAS * N_COLS,
  localparam int CW   = ($clog2(KEYS) < 1) ? 1 : $clog2(KEYS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_FILAS-1:0] filas,
  output logic [N_COLS-1:0]  columnas,
  output logic [CW-1:0]      codigo,
  output logic               tecla_valida,
  input  logic               tecla_listo,
  output logic               presionada,
  output logic               desborde
);

  localparam int SW   = $clog2(SCAN_DIV);
  localparam int COLW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int DW   = $clog2(DEBOUNCE_FRAMES + 1);

  // Handshake: an event is transferred on any rising clk edge where tecla_valida and
  // tecla_listo are both 1; codigo holds steady while tecla_valida is 1 and not transferred.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAND  = 2'd1,
    PRESS = 2'd2
  } estado_t;

  estado_t estado;

  logic [N_FILAS-1:0] filas_m, filas_s;
  logic [SW-1:0]      scan_cnt;
  logic [COLW-1:0]    col_idx;
  logic [COLW-1:0]    col_sig;
  logic               muestra;
  logic               fin_trama;

  logic [1:0]    acc_n;
  logic [CW-1:0] acc_idx;
  logic [1:0]    n_col;
  logic [CW-1:0] idx_col;
  logic [2:0]    suma;
  logic [1:0]    n_trama;
  logic [CW-1:0] idx_trama;
  logic          cls_none, cls_single;

  logic [CW-1:0] cand;
  logic [DW-1:0] cnt, cnt_sig;
  logic [DW-1:0] rel, rel_sig;
  logic          emit;

  always_ff @(posedge clk) begin
    if (rst) begin
      filas_m <= '1;
      filas_s <= '1;
    end else begin
      filas_m <= filas;
      filas_s <= filas_m;
    end
  end

  assign muestra   = (scan_cnt == SW'(SCAN_DIV - 1));
  assign fin_trama = muestra && (col_idx == COLW'(N_COLS - 1));
  assign col_sig   = (col_idx == COLW'(N_COLS - 1)) ? '0 : col_idx + 1'b1;

  // columnas is registered so it moves together with col_idx on the wrap edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      col_idx  <= '0;
      columnas <= ~N_COLS'(1);
    end else if (muestra) begin
      scan_cnt <= '0;
      col_idx  <= col_sig;
      columnas <= ~(N_COLS'(1) << col_sig);
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Count low rows in the current column (saturating at 2) and remember the last one.
  always_comb begin
    n_col   = '0;
    idx_col = '0;
    for (int r = 0; r < N_FILAS; r++) begin
      if (!filas_s[r]) begin
        if (n_col != 2'd2) n_col = n_col + 2'd1;
        idx_col = CW'(r * N_COLS) + CW'(col_idx);
      end
    end
  end

  assign suma       = {1'b0, acc_n} + {1'b0, n_col};
  assign n_trama    = (suma >= 3'd2) ? 2'd2 : suma[1:0];
  assign idx_trama  = (n_col != 2'd0) ? idx_col : acc_idx;
  assign cls_none   = (n_trama == 2'd0);
  assign cls_single = (n_trama == 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_n   <= '0;
      acc_idx <= '0;
    end else if (muestra) begin
      if (fin_trama) begin
        acc_n   <= '0;
        acc_idx <= '0;
      end else begin
        acc_n   <= n_trama;
        acc_idx <= idx_trama;
      end
    end
  end

  assign cnt_sig = cnt + 1'b1;
  assign rel_sig = rel + 1'b1;

  always_comb begin
    emit = 1'b0;
    if (fin_trama && cls_single) begin
      if (estado == IDLE && DEBOUNCE_FRAMES == 1)
        emit = 1'b1;
      else if (estado == CAND && idx_trama == cand && cnt_sig == DW'(DEBOUNCE_FRAMES))
        emit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado       <= IDLE;
      cand         <= '0;
      cnt          <= '0;
      rel          <= '0;
      presionada   <= 1'b0;
      codigo       <= '0;
      tecla_valida <= 1'b0;
      desborde     <= 1'b0;
    end else begin
      if (fin_trama) begin
        case (estado)
          IDLE: begin
            if (cls_single) begin
              cand <= idx_trama;
              cnt  <= DW'(1);
              rel  <= '0;
              if (DEBOUNCE_FRAMES == 1) begin
                estado     <= PRESS;
                presionada <= 1'b1;
              end else begin
                estado <= CAND;
              end
            end
          end
          CAND: begin
            if (cls_single && idx_trama == cand) begin
              cnt <= cnt_sig;
              if (cnt_sig == DW'(DEBOUNCE_FRAMES)) begin
                estado     <= PRESS;
                presionada <= 1'b1;
                rel        <= '0;
              end
            end else if (cls_single) begin
              cand <= idx_trama;
              cnt  <= DW'(1);
            end else begin
              estado <= IDLE;
            end
          end
          PRESS: begin
            // A different single key counts as the held key going away.
            if (cls_none || (cls_single && idx_trama != cand)) begin
              rel <= rel_sig;
              if (rel_sig == DW'(DEBOUNCE_FRAMES)) begin
                estado     <= IDLE;
                presionada <= 1'b0;
              end
            end else begin
              rel <= '0;
            end
          end
          default: estado <= IDLE;
        endcase
      end

      if (emit) begin
        if (!tecla_valida || tecla_listo) begin
          codigo       <= idx_trama;
          tecla_valida <= 1'b1;
        end else begin
          desborde <= 1'b1;
        end
      end else if (tecla_valida && tecla_listo) begin
        tecla_valida <= 1'b0;
      end
    end
  end

endmodule

// File: doc/teclado_matriz.md
# teclado_matriz

Parametrised matrix-keypad scanner for an N_FILAS x N_COLS key matrix with active-low rows and columns. The block drives one column low at a time, samples the rows through a synchroniser and debounces keys over whole scan frames. It rejects multi-key frames and delivers each debounced press as a single event on a valid/ready handshake. It sits between the keypad pins and the application logic (entry/display FSMs), replacing ad-hoc per-column decoding.

## Interface
- N_FILAS, 4, number of row inputs (>=1)
- N_COLS, 4, number of column outputs (>=1)
- SCAN_DIV, 13_500, clk cycles each column is driven (>=4; ~0.5 ms @27 MHz)
- DEBOUNCE_FRAMES, 4, consecutive identical frames needed to accept a press or a release (>=1)
- Derived: CW = max(1, $clog2(N_FILAS*N_COLS))

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- filas  in  N_FILAS  row pins, asynchronous, active-low (bit i low = row i conducting)
- columnas  out  N_COLS  column drive, one-cold (exactly one bit low)
- codigo  out  CW  key index = fila*N_COLS + col; stable while tecla_valida=1
- tecla_valida  out  1  event pending
- tecla_listo  in  1  consumer ready; transfer when tecla_valida & tecla_listo
- presionada  out  1  level: a debounced key is currently held
- desborde  out  1  sticky: an event was lost because the previous one was not taken; cleared only by rst

## Operation
- filas pass through a 2-flop synchroniser before use.
- Scan: counter scan_cnt counts 0..SCAN_DIV-1. col_idx advances on wrap, N_COLS-1 -> 0. columnas = ~(1<<col_idx).
- Sample: synchronised rows are sampled on the last dwell cycle of each column (scan_cnt==SCAN_DIV-1). The active-low rows are accumulated into a frame record: number of low bits seen, plus the index of the last one.
- Frame end = sample of column N_COLS-1. Classification: NONE (0 keys), SINGLE(c) (exactly 1 key), MULTI (>=2 keys). The record is cleared for the next frame.
- Debounce FSM, evaluated once per frame end:
  - IDLE:
    - SINGLE(c) -> CAND with cand=c, cnt=1. If DEBOUNCE_FRAMES==1, go straight to PRESS and emit.
    - NONE/MULTI -> stay.
  - CAND:
    - SINGLE(cand) -> cnt++. When cnt reaches DEBOUNCE_FRAMES -> PRESS and emit event(cand).
    - SINGLE(other) -> restart with cand=other, cnt=1.
    - NONE/MULTI -> IDLE.
  - PRESS:
    - NONE -> rel++. When rel reaches DEBOUNCE_FRAMES -> IDLE.
    - SINGLE(cand) or MULTI -> rel=0 and stay. No new event; a second key added is ignored.
    - SINGLE(other) -> counts as release (rel++).
- presionada = (state==PRESS).
- Event output (1-deep):
  - tecla_valida=0: emit loads codigo and sets tecla_valida.
  - tecla_valida=1 & tecla_listo=1 in the same cycle as emit: codigo updates, tecla_valida stays 1, no overflow.
  - tecla_valida=1 & tecla_listo=0 at emit: event dropped, codigo unchanged, desborde<=1.
  - Transfer with no emit: tecla_valida<=0 next cycle.
- rst asserted mid-operation, including mid-press or with an event pending, discards everything. After rst deasserts, a key still held must re-debounce from IDLE.

## Timing
- Reset values:
  - columnas = ~1 (col 0 low)
  - codigo = 0
  - tecla_valida = 0, presionada = 0, desborde = 0
  - scan_cnt = 0, col_idx = 0, FSM = IDLE, synchroniser = all ones
- Frame length F = N_COLS*SCAN_DIV cycles.
- columnas is registered; it changes the cycle after scan_cnt wraps.
- Row settle: each column is sampled SCAN_DIV-1 cycles after it is driven, which covers the 2-cycle synchroniser.
- Press latency from a stable, bounce-free press: between (DEBOUNCE_FRAMES-1)*F and DEBOUNCE_FRAMES*F + F + 3 cycles. tecla_valida rises 1 cycle after the qualifying frame-end sample.
- Release is qualified after DEBOUNCE_FRAMES NONE frames; presionada falls 1 cycle after that frame end.
- tecla_listo may be held high permanently: each event then produces a 1-cycle tecla_valida pulse.

## Test plan
Common setup: N_FILAS=4, N_COLS=4, SCAN_DIV=4, DEBOUNCE_FRAMES=2 (F=16).
- Scan: rst then idle. Expect columnas 1110,1101,1011,0111 repeating, each held 4 cycles; outputs equal reset values during rst.
- Press: hold row 1 / column 2 (filas[1] low only while columnas[2] low) for 5 frames, tecla_listo=1. Expect exactly one tecla_valida pulse with codigo=6, presionada=1 until 2 NONE frames after release.
- Bounce: same key for 1 frame, then release. Expect no event, presionada stays 0.
- Multi-key: keys 0 and 5 held together. Expect no event. Pressing 5 first, debouncing it, then adding 0 gives one event codigo=5 and no second event.
- Overflow: tecla_listo=0; press/release key 3, then press/release key 9. Expect codigo=3 held, desborde=1; asserting tecla_listo clears tecla_valida next cycle while desborde stays 1.
- Reset mid-press: pulse rst while presionada=1 and key held. Expect all outputs to reset values, then a new codigo event after re-debounce.
